uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of uart_rx.
- Captures each single-cycle uart_rx_valid pulse (data byte or BREAK) and stores data bytes in a DEPTH-entry first-word-fall-through FIFO.
- Presents stored bytes to the consumer (CPU bridge or command parser) over a valid/ready handshake.
- Flags BREAK events and dropped bytes in sticky status bits.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX buffer and the upcoming TX FIFO.
package uart_pkg;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH FIFO storage: registered write, combinational read.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    // Contents are deliberately left unreset so the array maps onto plain RAM.
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: FWFT byte FIFO with sticky BREAK/overflow flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_rx_valid,
    input  logic [WIDTH-1:0]       uart_rx_data,
    input  logic                   uart_rx_break,
    input  logic                   flush,
    input  logic                   clr_status,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic                   rx_break
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [AW:0]     COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     COUNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          rx_break_reg, rx_break_next;
    logic [WIDTH-1:0] mem_rd_data;

    logic push, pop, full_int, accept, ovf_set, brk_set;

    assign full_int = (count_reg == COUNT_FULL);
    assign push     = uart_rx_valid & ~uart_rx_break;
    assign pop      = (count_reg != '0) & rd_ready;
    // A full FIFO still takes a byte when the consumer frees a slot in the same cycle.
    assign accept   = push & (~full_int | pop) & ~flush;
    assign ovf_set  = push & full_int & ~pop & ~flush;
    assign brk_set  = uart_rx_valid & uart_rx_break;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = (overflow_reg & ~clr_status) | ovf_set;
        rx_break_next = (rx_break_reg & ~clr_status) | brk_set;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (accept) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (accept && !pop) begin
                count_next = count_reg + COUNT_ONE;
            end else if (pop && !accept) begin
                count_next = count_reg - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rx_break_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rx_break_reg <= rx_break_next;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (uart_rx_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rd_data)
    );

    // Masking keeps rd_data at zero out of reset, when storage is still uninitialised.
    assign rd_data  = (count_reg != '0) ? mem_rd_data : '0;
    assign rd_valid = (count_reg != '0);
    assign count    = count_reg;
    assign full     = full_int;
    assign overflow = overflow_reg;
    assign rx_break = rx_break_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model plus a negedge monitor.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_RX_FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx_valid = 1'b0;
    uart_byte_t uart_rx_data = '0;
    logic       uart_rx_break = 1'b0;
    logic       flush = 1'b0;
    logic       clr_status = 1'b0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    uart_byte_t rd_data;
    logic [$clog2(DEPTH):0] count;
    logic       full, overflow, rx_break;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .flush         (flush),
        .clr_status    (clr_status),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .rx_break      (rx_break)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    // Reference: the FIFO is just an ordered queue of accepted bytes.
    uart_byte_t exp_q[$];
    bit m_ovf = 1'b0, m_brk = 1'b0;
    int m_sz;
    bit m_pop, m_push, m_ovf_set, m_brk_set;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_sz      = exp_q.size();
            m_pop     = (m_sz > 0) && rd_ready;
            m_push    = uart_rx_valid && !uart_rx_break;
            m_brk_set = uart_rx_valid && uart_rx_break;
            m_ovf_set = 1'b0;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_push && m_sz == DEPTH && !m_pop) m_ovf_set = 1'b1;
                if (m_pop) void'(exp_q.pop_front());
                if (m_push && !m_ovf_set) exp_q.push_back(uart_rx_data);
            end
            m_ovf = (m_ovf && !clr_status) || m_ovf_set;
            m_brk = (m_brk && !clr_status) || m_brk_set;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
            chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("rx_break", 32'(rx_break), 32'(m_brk));
            if (exp_q.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
                if (rd_ready && !flush && !reset)
                    $display("read 0x%02h (expected 0x%02h) count=%0d", rd_data, exp_q[0], count);
            end
        end
    end

    task automatic step(input bit v, input uart_byte_t d, input bit b,
                        input bit r, input bit f, input bit c);
        uart_rx_valid = v;
        uart_rx_data  = d;
        uart_rx_break = b;
        rd_ready      = r;
        flush         = f;
        clr_status    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input uart_byte_t d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && exp_q.size() > 0; k++)
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pushed;
        bit v;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        idle();

        // In-order delivery with one-cycle latency
        push(8'hA5); push(8'h3C); push(8'h00);
        idle();
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(i));
        push(8'hFF);
        idle();
        drain();

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(8'h20 + i));
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // BREAK handling and clr_status priority
        push(8'h12);
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        drain();

        // Flush beats a concurrent push; set overflow first so its retention is visible
        for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(8'h40 + i));
        push(8'hEE);
        drain();
        for (int i = 0; i < 5; i++) push(uart_byte_t'(8'h60 + i));
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        push(8'h88);
        idle();
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic wrapping the pointers
        pushed = 0;
        for (int k = 0; k < 2000 && pushed < 40; k++) begin
            v = ($urandom_range(0, 9) < 4);
            if (v) pushed++;
            step(v, uart_byte_t'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        drain();

        // Reset mid-stream, including a frame arriving while reset is held
        push(8'hC1); push(8'hC2);
        step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'hC3);
        reset = 1'b1;
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset rx_break", 32'(rx_break), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h99;
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
        reset = 1'b0;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
